// File: rtl/lsu_axi_bridge.sv
// Bridge from the LSU's level-held load/store requests to a single-outstanding AXI4-Lite master.
// Store data and strobes are lane-aligned on the way out, and load data is right-justified on the way back.
module lsu_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    input  logic [7:0]        lsu_rstrb,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,
    output logic              lsu_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, RESP} state_t;

    state_t            state;
    logic [1:0]        offset;
    logic              store_req;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_size;
    logic              req_fault;
    logic              aw_left;
    logic              w_left;

    // Bytes may sit anywhere; halves need an even address; words need a word-aligned address.
    function automatic logic size_fault(input logic [7:0] size, input logic [1:0] lane);
        case (size)
            8'h01:   size_fault = 1'b0;
            8'h03:   size_fault = lane[0];
            8'h0f:   size_fault = (lane != 2'b00);
            default: size_fault = 1'b1;
        endcase
    endfunction

    assign store_req = lsu_awvalid & lsu_wvalid;
    assign req_addr  = store_req ? lsu_awaddr : lsu_araddr;
    assign req_size  = store_req ? lsu_wstrb : lsu_rstrb;
    assign req_fault = size_fault(req_size, req_addr[1:0]);

    // A write channel is still owed a handshake while its valid is up and the slave is not ready.
    assign aw_left = awvalid & ~awready;
    assign w_left  = wvalid & ~wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            offset     <= 2'b00;
            lsu_rdata  <= '0;
            lsu_rvalid <= 1'b0;
            lsu_wready <= 1'b0;
            lsu_err    <= 1'b0;
            araddr     <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awaddr     <= '0;
            awvalid    <= 1'b0;
            wdata      <= '0;
            wstrb      <= 4'h0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (store_req || lsu_arvalid) begin
                        offset <= req_addr[1:0];
                        if (req_fault) begin
                            lsu_err    <= 1'b1;
                            lsu_wready <= store_req;
                            lsu_rvalid <= ~store_req;
                            if (!store_req) begin
                                lsu_rdata <= '0;
                            end
                            state <= RESP;
                        end else if (store_req) begin
                            awaddr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            wdata   <= lsu_wdata << {req_addr[1:0], 3'b000};
                            wstrb   <= lsu_wstrb[3:0] << req_addr[1:0];
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR;
                        end else begin
                            araddr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            arvalid <= 1'b1;
                            state   <= RD_A;
                        end
                    end
                end
                RD_A: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_D;
                    end
                end
                RD_D: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        lsu_rdata  <= rdata >> {offset, 3'b000};
                        lsu_err    <= (rresp != 2'b00);
                        lsu_rvalid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wready) begin
                        wvalid <= 1'b0;
                    end
                    if (!aw_left && !w_left) begin
                        bready <= 1'b1;
                        state  <= WR_B;
                    end
                end
                WR_B: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        lsu_err    <= (bresp != 2'b00);
                        lsu_wready <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    lsu_rvalid <= 1'b0;
                    lsu_wready <= 1'b0;
                    lsu_err    <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Bench for lsu_axi_bridge: hand-built vector table, corner sequences and randomized transactions
// against an AXI-Lite slave model with per-channel delays and a transaction-level expectation model.
module tb_lsu_axi_bridge;

    logic        clk;
    logic        rst_n;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid;
    logic [7:0]  lsu_rstrb;
    logic [31:0] lsu_rdata;
    logic        lsu_rvalid;
    logic [31:0] lsu_awaddr;
    logic        lsu_awvalid;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wstrb;
    logic        lsu_wvalid;
    logic        lsu_wready;
    logic        lsu_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    lsu_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_err(lsu_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_store;
        logic [31:0] addr;
        logic [7:0]  size;
        logic [31:0] data;
        logic [31:0] rword;
        logic [1:0]  resp;
        int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
        bit          exp_fault;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        bit          exp_wfirst;
    } vec_t;

    vec_t        tbl[11];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_rdata;

    int          s_ar_dly, s_r_dly, s_aw_dly, s_w_dly, s_b_dly;
    logic [31:0] s_rword;
    logic [1:0]  s_rresp, s_bresp;
    bit          s_scramble;

    bit          obs_ar_seen, obs_aw_seen, obs_w_seen, obs_wfirst;
    logic [31:0] obs_araddr, obs_awaddr, obs_wdata;
    logic [3:0]  obs_wstrb;
    int          obs_proto;

    function automatic vec_t mkVec(bit st, logic [31:0] addr, logic [7:0] size, logic [31:0] data,
                                   logic [31:0] rword, logic [1:0] resp, int ard, int rd, int awd,
                                   int wd, int bd, bit fault, logic [31:0] e_addr, logic [31:0] e_wdata,
                                   logic [3:0] e_wstrb, logic e_err, logic [31:0] e_rdata, int e_lat,
                                   bit e_wfirst);
        vec_t v;
        v.is_store = st; v.addr = addr; v.size = size; v.data = data; v.rword = rword; v.resp = resp;
        v.ar_dly = ard; v.r_dly = rd; v.aw_dly = awd; v.w_dly = wd; v.b_dly = bd;
        v.exp_fault = fault; v.exp_addr = e_addr; v.exp_wdata = e_wdata; v.exp_wstrb = e_wstrb;
        v.exp_err = e_err; v.exp_rdata = e_rdata; v.exp_lat = e_lat; v.exp_wfirst = e_wfirst;
        return v;
    endfunction

    // Transaction-level expectation: alignment rules, lane shifts and handshake-count latency.
    function automatic vec_t modelVec(bit st, logic [31:0] addr, logic [7:0] size, logic [31:0] data,
                                      logic [31:0] rword, logic [1:0] resp, int ard, int rd, int awd,
                                      int wd, int bd);
        vec_t v;
        int   off;
        bit   legal;
        bit   fault;
        off   = int'(addr % 4);
        legal = (size == 8'h01) || (size == 8'h03 && off % 2 == 0) || (size == 8'h0f && off == 0);
        fault = !legal;
        v = mkVec(st, addr, size, data, rword, resp, ard, rd, awd, wd, bd, fault, 32'h0, 32'h0, 4'h0,
                  1'b0, 32'h0, 0, 1'b0);
        v.exp_addr   = addr - 32'(off);
        v.exp_wdata  = data << (8 * off);
        v.exp_wstrb  = 4'((size % 16) << off);
        v.exp_err    = fault || (resp != 2'b00);
        v.exp_rdata  = st ? model_rdata : (fault ? 32'h0 : (rword >> (8 * off)));
        v.exp_lat    = fault ? 1 : (st ? 3 + ((awd > wd) ? awd : wd) + bd : 3 + ard + rd);
        v.exp_wfirst = (wd < awd);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Acts as the AXI slave each cycle until the LSU sees a completion pulse; returns cycles taken.
    task automatic serviceUntilPulse(output int lat);
        int   ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
        logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
        obs_ar_seen = 0; obs_aw_seen = 0; obs_w_seen = 0; obs_wfirst = 0; obs_proto = 0;
        obs_araddr = 0; obs_awaddr = 0; obs_wdata = 0; obs_wstrb = 0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (p_arv && !p_arr && !arvalid) obs_proto++;
            if (p_awv && !p_awr && !awvalid) obs_proto++;
            if (p_wv && !p_wr && !wvalid) obs_proto++;
            if (lsu_rvalid || lsu_wready) begin
                lat = c;
                arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
                break;
            end
            if (arvalid) begin obs_ar_seen = 1; obs_araddr = araddr; end
            if (awvalid) begin obs_aw_seen = 1; obs_awaddr = awaddr; end
            if (wvalid) begin obs_w_seen = 1; obs_wdata = wdata; obs_wstrb = wstrb; end
            if (obs_w_seen && !wvalid && awvalid) obs_wfirst = 1;
            arready = arvalid && (ar_cnt >= s_ar_dly);
            if (arvalid) ar_cnt++;
            awready = awvalid && (aw_cnt >= s_aw_dly);
            if (awvalid) aw_cnt++;
            wready = wvalid && (w_cnt >= s_w_dly);
            if (wvalid) w_cnt++;
            rvalid = rready && (r_cnt >= s_r_dly);
            if (rready) r_cnt++;
            rdata = rvalid ? s_rword : $urandom();
            rresp = rvalid ? s_rresp : 2'($urandom());
            bvalid = bready && (b_cnt >= s_b_dly);
            if (bready) b_cnt++;
            bresp = bvalid ? s_bresp : 2'($urandom());
            p_arv = arvalid; p_arr = arready; p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
            if (s_scramble) begin
                lsu_araddr = $urandom(); lsu_awaddr = $urandom(); lsu_wdata = $urandom();
                lsu_rstrb = 8'($urandom()); lsu_wstrb = 8'($urandom());
            end
        end
        if (lat < 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL pulse timeout: got no completion pulse, expected one within 100 cycles");
        end
    endtask

    task automatic applyStimulus(input vec_t v, output int lat, output logic [1:0] pulse,
                                 output logic err, output logic [31:0] rd, output logic [2:0] after);
        @(negedge clk);
        s_ar_dly = v.ar_dly; s_r_dly = v.r_dly; s_aw_dly = v.aw_dly; s_w_dly = v.w_dly; s_b_dly = v.b_dly;
        s_rword = v.rword; s_rresp = v.resp; s_bresp = v.resp;
        if (v.is_store) begin
            lsu_awaddr = v.addr; lsu_wdata = v.data; lsu_wstrb = v.size;
            lsu_awvalid = 1; lsu_wvalid = 1;
            lsu_arvalid = 0; lsu_araddr = $urandom(); lsu_rstrb = 8'($urandom());
        end else begin
            lsu_araddr = v.addr; lsu_rstrb = v.size; lsu_arvalid = 1;
            lsu_awvalid = 0; lsu_wvalid = 0; lsu_awaddr = $urandom(); lsu_wdata = $urandom();
        end
        serviceUntilPulse(lat);
        pulse = {lsu_rvalid, lsu_wready};
        err   = lsu_err;
        rd    = lsu_rdata;
        lsu_arvalid = 0; lsu_awvalid = 0; lsu_wvalid = 0;
        @(negedge clk);
        after = {lsu_rvalid, lsu_wready, lsu_err};
    endtask

    task automatic runAndCheck(input vec_t v, input string tag);
        int          lat;
        logic [1:0]  pulse;
        logic        err;
        logic [31:0] rd;
        logic [2:0]  after;
        applyStimulus(v, lat, pulse, err, rd, after);
        checkOutput({tag, " latency"}, lat, v.exp_lat);
        checkOutput({tag, " pulse kind"}, 32'(pulse), v.is_store ? 32'h1 : 32'h2);
        checkOutput({tag, " lsu_err"}, 32'(err), 32'(v.exp_err));
        checkOutput({tag, " lsu_rdata"}, rd, v.exp_rdata);
        checkOutput({tag, " pulse width"}, 32'(after), 32'h0);
        if (v.exp_fault) begin
            checkOutput({tag, " axi traffic"}, {29'h0, obs_ar_seen, obs_aw_seen, obs_w_seen}, 32'h0);
        end else if (v.is_store) begin
            checkOutput({tag, " awaddr"}, obs_awaddr, v.exp_addr);
            checkOutput({tag, " wdata"}, obs_wdata, v.exp_wdata);
            checkOutput({tag, " wstrb"}, 32'(obs_wstrb), 32'(v.exp_wstrb));
            checkOutput({tag, " wvalid first"}, 32'(obs_wfirst), 32'(v.exp_wfirst));
            checkOutput({tag, " protocol"}, {31'h0, obs_ar_seen} + 32'(obs_proto), 32'h0);
        end else begin
            checkOutput({tag, " araddr"}, obs_araddr, v.exp_addr);
            checkOutput({tag, " protocol"}, {31'h0, obs_aw_seen} + 32'(obs_proto), 32'h0);
        end
        model_rdata = v.exp_rdata;
    endtask

    initial begin
        int          lat;
        bit          got;
        bit          st;
        int          r;
        logic [7:0]  size;
        logic [7:0]  bad_sizes[5];
        logic [1:0]  resp;
        vec_t        v;

        rst_n = 0;
        lsu_araddr = 0; lsu_arvalid = 0; lsu_rstrb = 0; lsu_awaddr = 0; lsu_awvalid = 0;
        lsu_wdata = 0; lsu_wstrb = 0; lsu_wvalid = 0;
        arready = 0; rdata = 0; rresp = 0; rvalid = 0; awready = 0; wready = 0; bresp = 0; bvalid = 0;
        s_scramble = 0; model_rdata = 0;
        bad_sizes[0] = 8'h00; bad_sizes[1] = 8'h07; bad_sizes[2] = 8'h1f;
        bad_sizes[3] = 8'hff; bad_sizes[4] = 8'h02;

        tbl[0]  = mkVec(0, 32'h8000_0010, 8'h0f, 32'h0, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 0, 0, 32'h8000_0010, 32'h0, 4'h0, 0, 32'hDEADBEEF, 3, 0);
        tbl[1]  = mkVec(0, 32'h8000_0013, 8'h01, 32'h0, 32'hAB112233, 2'b00, 0, 0, 0, 0, 0, 0, 32'h8000_0010, 32'h0, 4'h0, 0, 32'h0000_00AB, 3, 0);
        tbl[2]  = mkVec(1, 32'h8000_0022, 8'h03, 32'h0000BEEF, 32'h0, 2'b00, 0, 0, 3, 0, 0, 0, 32'h8000_0020, 32'hBEEF0000, 4'hC, 0, 32'h0000_00AB, 6, 1);
        tbl[3]  = mkVec(0, 32'h8000_0002, 8'h0f, 32'h0, 32'h12345678, 2'b00, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 4'h0, 1, 32'h0, 1, 0);
        tbl[4]  = mkVec(1, 32'h8000_0040, 8'h0f, 32'h12345678, 32'h0, 2'b10, 0, 0, 0, 0, 0, 0, 32'h8000_0040, 32'h12345678, 4'hF, 1, 32'h0, 3, 0);
        tbl[5]  = mkVec(0, 32'h8000_0006, 8'h03, 32'h0, 32'h11223344, 2'b00, 2, 1, 0, 0, 0, 0, 32'h8000_0004, 32'h0, 4'h0, 0, 32'h0000_1122, 6, 0);
        tbl[6]  = mkVec(1, 32'h1000_0001, 8'h01, 32'h000000A5, 32'h0, 2'b00, 0, 0, 0, 2, 0, 0, 32'h1000_0000, 32'h0000A500, 4'h2, 0, 32'h0000_1122, 5, 0);
        tbl[7]  = mkVec(0, 32'h0000_0000, 8'h07, 32'h0, 32'hFFFFFFFF, 2'b00, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 4'h0, 1, 32'h0, 1, 0);
        tbl[8]  = mkVec(0, 32'h0000_0020, 8'h0f, 32'h0, 32'hCAFEF00D, 2'b11, 0, 0, 0, 0, 0, 0, 32'h0000_0020, 32'h0, 4'h0, 1, 32'hCAFEF00D, 3, 0);
        tbl[9]  = mkVec(1, 32'h0000_0003, 8'h03, 32'h00001234, 32'h0, 2'b00, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 4'h0, 1, 32'hCAFEF00D, 1, 0);
        tbl[10] = mkVec(1, 32'h0000_0044, 8'h0f, 32'hA1B2C3D4, 32'h0, 2'b00, 0, 0, 1, 1, 2, 0, 32'h0000_0044, 32'hA1B2C3D4, 4'hF, 0, 32'hCAFEF00D, 6, 0);

        // Reset values, both while held and just after release with no request pending.
        repeat (3) @(negedge clk);
        checkOutput("reset lsu outputs", {28'h0, lsu_rvalid, lsu_wready, lsu_err, 1'b0} | lsu_rdata, 32'h0);
        checkOutput("reset axi valids", {27'h0, arvalid, rready, awvalid, wvalid, bready}, 32'h0);
        checkOutput("reset araddr", araddr, 32'h0);
        checkOutput("reset awaddr", awaddr, 32'h0);
        checkOutput("reset wdata", wdata, 32'h0);
        checkOutput("reset wstrb", 32'(wstrb), 32'h0);
        rst_n = 1;
        @(negedge clk);
        checkOutput("idle after release", {27'h0, arvalid, awvalid, wvalid, lsu_rvalid, lsu_wready}, 32'h0);

        foreach (tbl[i]) begin
            runAndCheck(tbl[i], $sformatf("vec%0d", i));
        end

        // Simultaneous load and store: the store wins, the load follows in the next IDLE cycle.
        @(negedge clk);
        s_ar_dly = 0; s_r_dly = 0; s_aw_dly = 0; s_w_dly = 0; s_b_dly = 0;
        s_rword = 32'h600DF00D; s_rresp = 2'b00; s_bresp = 2'b10;
        lsu_araddr = 32'h0000_0030; lsu_rstrb = 8'h0f; lsu_arvalid = 1;
        lsu_awaddr = 32'h0000_0040; lsu_wdata = 32'h55; lsu_wstrb = 8'h0f; lsu_awvalid = 1; lsu_wvalid = 1;
        serviceUntilPulse(lat);
        checkOutput("prio store latency", lat, 3);
        checkOutput("prio store pulse", {30'h0, lsu_rvalid, lsu_wready}, 32'h1);
        checkOutput("prio store bresp err", 32'(lsu_err), 32'h1);
        checkOutput("prio load deferred", 32'(obs_ar_seen), 32'h0);
        lsu_awvalid = 0; lsu_wvalid = 0;
        serviceUntilPulse(lat);
        checkOutput("prio load latency", lat, 4);
        checkOutput("prio load pulse", {30'h0, lsu_rvalid, lsu_wready}, 32'h2);
        checkOutput("prio load err", 32'(lsu_err), 32'h0);
        checkOutput("prio load rdata", lsu_rdata, 32'h600DF00D);
        checkOutput("prio load araddr", obs_araddr, 32'h0000_0030);
        lsu_arvalid = 0;

        // Reset while waiting for read data aborts everything immediately.
        @(negedge clk);
        lsu_araddr = 32'h0000_0100; lsu_rstrb = 8'h0f; lsu_arvalid = 1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rready) begin got = 1; break; end
            arready = arvalid;
        end
        arready = 0;
        checkOutput("reach RD_D", 32'(got), 32'h1);
        rst_n = 0;
        #1;
        checkOutput("abort valids", {29'h0, arvalid, rready, bready}, 32'h0);
        checkOutput("abort lsu pulses", {29'h0, lsu_rvalid, lsu_wready, lsu_err}, 32'h0);
        checkOutput("abort lsu_rdata", lsu_rdata, 32'h0);
        lsu_arvalid = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checkOutput("idle after abort", {30'h0, arvalid, rready}, 32'h0);
        model_rdata = 0;
        runAndCheck(modelVec(0, 32'h0000_0104, 8'h0f, 32'h0, 32'h0BADCAFE, 2'b00, 0, 0, 0, 0, 0), "post-reset load");

        // Randomized transactions; request fields are scrambled once sampled.
        s_scramble = 1;
        for (int n = 0; n < 150; n++) begin
            st = 1'($urandom());
            r  = $urandom_range(0, 9);
            if (r < 3) size = 8'h01;
            else if (r < 6) size = 8'h03;
            else if (r < 9) size = 8'h0f;
            else size = bad_sizes[$urandom_range(0, 4)];
            resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v = modelVec(st, $urandom(), size, $urandom(), $urandom(), resp,
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            runAndCheck(v, $sformatf("rand%0d", n));
        end
        s_scramble = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
